// File: rtl/fpu_pkg.sv
// Shared FP types and constants for FPU-side blocks.
//   fp32_t        : raw IEEE-754 single-precision bit pattern
//   fp_operands_t : operand pair for a two-input FP op
//   FPADD_LATENCY : issue-to-result latency of the 2-stage FP adder
package fpu_pkg;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    fp32_t a;
    fp32_t b;
  } fp_operands_t;

  localparam int FPADD_LATENCY = 2;

  localparam fp32_t FP_ONE   = 32'h3F80_0000;
  localparam fp32_t FP_TWO   = 32'h4000_0000;
  localparam fp32_t FP_THREE = 32'h4040_0000;

endpackage

// File: rtl/fpu_resp_fifo.sv
// Circular response buffer, DEPTH x WIDTH, with occupancy count.
//   clk, reset   : clock, synchronous active-high reset
//   i_enq        : write i_enq_data at the tail (ignored when full)
//   i_deq        : pop the head (ignored when empty)
//   o_deq_data   : head entry (don't-care when empty)
//   o_count      : entries held, 0..DEPTH
//   o_full/empty : occupancy flags
// No write-to-read bypass: an entry becomes visible the cycle after it is written.
module fpu_resp_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_enq,
  input  logic [WIDTH-1:0]         i_enq_data,
  input  logic                     i_deq,
  output logic [WIDTH-1:0]         o_deq_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_enq;
  logic             w_do_deq;

  assign o_full   = (r_count == CNT_FULL);
  assign o_empty  = (r_count == '0);
  assign w_do_enq = i_enq & ~o_full;
  // Read qualifies on the pre-write count, so a same-cycle write never
  // aliases the slot being read.
  assign w_do_deq = i_deq & ~o_empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_enq) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_deq) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy lives in the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_enq) r_mem[r_wr_ptr] <= i_enq_data;
  end

  assign o_deq_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/fpu_valrdy_issue.sv
// Val/rdy front end for a fixed-latency, valid-only FP pipeline.
//   req_val/req_rdy/req_a/req_b     : request stream (operand pair)
//   resp_val/resp_rdy/resp_msg      : response stream (result)
//   pipe_in_val/pipe_in0/pipe_in1   : issue strobe and operands to the unit
//   pipe_out_val/pipe_out           : result strobe and data from the unit
//   err                             : sticky protocol error
// Every accepted request holds one credit from issue until its response
// leaves the FIFO, so the FIFO always has room for every in-flight result.
module fpu_valrdy_issue
  import fpu_pkg::*;
#(
  parameter int LATENCY = FPADD_LATENCY,
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [WIDTH-1:0] resp_msg,
  output logic             pipe_in_val,
  output logic [WIDTH-1:0] pipe_in0,
  output logic [WIDTH-1:0] pipe_in1,
  input  logic             pipe_out_val,
  input  logic [WIDTH-1:0] pipe_out,
  output logic             err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [CW:0]   CRED_TOTAL = (CW+1)'(DEPTH);

  logic [CW-1:0] r_inflight;
  logic          r_err;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_cred_used;
  logic          w_full;
  logic          w_empty;
  logic          w_issue;
  logic          w_spur;
  logic          w_ovf;
  logic          w_retire;
  logic          w_enq;
  logic          w_deq;
  logic          w_unused_cfg;

  // The credit scheme itself is latency-agnostic; LATENCY only documents
  // the attached unit and guides the choice of DEPTH.
  assign w_unused_cfg = (LATENCY < 1);

  // Ready depends on registers only: no path from req_val or resp_rdy.
  assign w_cred_used = {1'b0, r_inflight} + {1'b0, w_count};
  assign req_rdy     = (w_cred_used < CRED_TOTAL);
  assign w_issue     = req_val & req_rdy;

  assign pipe_in_val = w_issue;
  assign pipe_in0    = req_a;
  assign pipe_in1    = req_b;

  // A result with nothing in flight is spurious: dropped, counters untouched.
  // A result arriving into a full FIFO is dropped but still retires its op.
  assign w_spur   = pipe_out_val & (r_inflight == '0);
  assign w_retire = pipe_out_val & ~w_spur;
  assign w_ovf    = w_retire & w_full;
  assign w_enq    = w_retire & ~w_full;

  assign resp_val = ~w_empty;
  assign w_deq    = resp_val & resp_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      case ({w_issue, w_retire})
        2'b10:   r_inflight <= r_inflight + CNT_ONE;
        2'b01:   r_inflight <= r_inflight - CNT_ONE;
        default: r_inflight <= r_inflight;
      endcase
      if (w_spur | w_ovf) r_err <= 1'b1;
    end
  end

  assign err = r_err;

  fpu_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_resp_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_enq      (w_enq),
    .i_enq_data (pipe_out),
    .i_deq      (w_deq),
    .o_deq_data (resp_msg),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

endmodule

// File: tb/tb_fpu_valrdy_issue.sv
// Bench for fpu_valrdy_issue with an attached 2-stage FP adder model.
module tb_fpu_valrdy_issue;
  import fpu_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_val = 1'b0;
  logic         req_rdy;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         resp_val;
  logic         resp_rdy = 1'b0;
  logic [W-1:0] resp_msg;
  logic         pipe_in_val;
  logic [W-1:0] pipe_in0, pipe_in1;
  logic         pipe_out_val;
  logic [W-1:0] pipe_out;
  logic         err;

  logic         spur = 1'b0;
  logic [W-1:0] spur_data = 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  fpu_valrdy_issue #(.LATENCY(LAT), .DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .pipe_in_val(pipe_in_val), .pipe_in0(pipe_in0), .pipe_in1(pipe_in1),
    .pipe_out_val(pipe_out_val), .pipe_out(pipe_out), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(string nm, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  // fp32 <-> real for normal values and zero (all bench values are exact).
  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real f2r(logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] fp_add(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Attached 2-stage adder; valid bits clear with the shared reset.
  logic         s1_val, s2_val;
  logic [W-1:0] s1_res, s2_res;
  always @(posedge clk) begin
    if (reset) begin
      s1_val <= 1'b0; s2_val <= 1'b0; s1_res <= '0; s2_res <= '0;
    end else begin
      s1_val <= pipe_in_val;
      s1_res <= fp_add(pipe_in0, pipe_in1);
      s2_val <= s1_val;
      s2_res <= s1_res;
    end
  end
  assign pipe_out_val = s2_val | spur;
  assign pipe_out     = s2_val ? s2_res : (spur ? spur_data : '0);

  // Reference model: every accepted request is one outstanding credit until
  // its response is taken; its result becomes visible LAT+1 cycles after issue.
  typedef struct {
    logic [31:0] v;
    int          vis;
  } ent_t;
  ent_t q[$];
  int   cyc = 0;
  logic err_exp = 1'b0;

  task automatic model_cycle();
    logic exp_rdy, exp_rv, fire;
    bit   pipe_busy;
    exp_rdy = (q.size() < DEPTH);
    exp_rv  = (q.size() != 0) && (q[0].vis <= cyc);
    fire    = req_val && exp_rdy;
    chkb("req_rdy", req_rdy, exp_rdy);
    chkb("resp_val", resp_val, exp_rv);
    if (exp_rv) chk("resp_msg", resp_msg, q[0].v);
    chkb("pipe_in_val", pipe_in_val, fire);
    if (fire) begin
      chk("pipe_in0", pipe_in0, req_a);
      chk("pipe_in1", pipe_in1, req_b);
    end
    chkb("err", err, err_exp);
    pipe_busy = 0;
    foreach (q[i]) if (q[i].vis > cyc) pipe_busy = 1;
    if (spur && !pipe_busy) err_exp = 1'b1;
    if (exp_rv && resp_rdy) void'(q.pop_front());
    if (fire) q.push_back('{fp_add(req_a, req_b), cyc + LAT + 1});
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      err_exp = 1'b0;
    end else begin
      model_cycle();
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tbl [8];
  int acc;

  initial begin
    tbl = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
            32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chkb("rst_req_rdy", req_rdy, 1'b1);
    chkb("rst_resp_val", resp_val, 1'b0);
    chkb("rst_err", err, 1'b0);
    chkb("rst_pipe_in_val", pipe_in_val, 1'b0);

    // Single op: 1.0 + 2.0 -> 3.0 three cycles later
    tick();
    req_val = 1'b1; req_a = FP_ONE; req_b = FP_TWO; resp_rdy = 1'b1;
    @(negedge clk);
    chkb("single_issue", pipe_in_val, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      req_val = 1'b0;
      @(negedge clk);
      if (k < 3) chkb("single_early", resp_val, 1'b0);
      else begin
        chkb("single_val", resp_val, 1'b1);
        chk("single_msg", resp_msg, FP_THREE);
        chkb("single_err", err, 1'b0);
      end
    end
    repeat (3) tick();

    // Streaming: k*1.0 + 1.0, back to back
    for (int c = 0; c <= 10; c++) begin
      tick();
      req_val = (c < 8);
      req_a   = r2f(real'(c));
      req_b   = FP_ONE;
      @(negedge clk);
      if (c < 8) chkb("stream_rdy", req_rdy, 1'b1);
      if (c >= 3) begin
        chkb("stream_val", resp_val, 1'b1);
        chk("stream_msg", resp_msg, tbl[c-3]);
      end
    end
    tick();
    req_val = 1'b0;
    repeat (4) tick();

    // Backpressure: exactly DEPTH accepted, then one pop frees one credit
    resp_rdy = 1'b0; req_val = 1'b1;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      req_a = r2f(real'(i + 10)); req_b = FP_TWO;
      @(negedge clk);
      if (req_rdy) acc++;
      tick();
    end
    chk("bp_accepted", acc, DEPTH);
    resp_rdy = 1'b1;
    @(negedge clk);
    chkb("bp_stalled_rdy", req_rdy, 1'b0);
    chkb("bp_resp_val", resp_val, 1'b1);
    tick();
    resp_rdy = 1'b0;
    @(negedge clk);
    chkb("bp_reassert", req_rdy, 1'b1);
    tick();
    @(negedge clk);
    chkb("bp_full_again", req_rdy, 1'b0);
    tick();
    req_val = 1'b0; resp_rdy = 1'b1;
    repeat (10) tick();

    // Concurrent issue, write and read with two results buffered
    resp_rdy = 1'b0;
    req_val = 1'b1; req_a = FP_ONE; req_b = FP_ONE;   tick();
    req_a = FP_TWO;   req_b = FP_ONE;                 tick();
    req_a = FP_TWO;   req_b = FP_TWO;                 tick();
    req_val = 1'b0;                                   tick();
    req_val = 1'b1; req_a = FP_THREE; req_b = FP_ONE; resp_rdy = 1'b1;
    @(negedge clk);
    chkb("conc_issue", pipe_in_val, 1'b1);
    chk("conc_msg0", resp_msg, 32'h4000_0000);
    tick();
    req_val = 1'b0;
    @(negedge clk);
    chkb("conc_rdy", req_rdy, 1'b1);
    chk("conc_msg1", resp_msg, 32'h4040_0000);
    tick();
    @(negedge clk);
    chk("conc_msg2", resp_msg, 32'h4080_0000);
    tick();
    @(negedge clk);
    chk("conc_msg3", resp_msg, 32'h4080_0000);
    repeat (4) tick();

    // Reset with two in flight and one buffered
    resp_rdy = 1'b0; req_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_a = r2f(real'(i + 1)); req_b = FP_ONE;
      tick();
    end
    req_val = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; resp_rdy = 1'b1;
    @(negedge clk);
    chkb("mrst_resp_val", resp_val, 1'b0);
    chkb("mrst_req_rdy", req_rdy, 1'b1);
    chkb("mrst_err", err, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      chkb("mrst_no_stale", resp_val, 1'b0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      tick();
      req_val  = ($urandom_range(0, 9) < 7);
      resp_rdy = ($urandom_range(0, 9) < 6);
      req_a    = r2f(real'($urandom_range(0, 2000)) / 2.0);
      req_b    = r2f(real'($urandom_range(0, 2000)) / 2.0);
    end
    tick();
    req_val = 1'b0; resp_rdy = 1'b1;
    repeat (12) tick();

    // Spurious result with nothing in flight
    spur = 1'b1;
    tick();
    spur = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chkb("spur_err", err, 1'b1);
      chkb("spur_no_resp", resp_val, 1'b0);
      chkb("spur_rdy", req_rdy, 1'b1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chkb("spur_err_cleared", err, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
